// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR generator and its receive-side checker,
// so both ends step the same polynomial.
package lfsr_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lfsr_state_t;

    localparam int LFSR_MAX_W = 32;

    // x^8+x^6+x^5+x^4+1, maximal length (period 255) for an 8-bit register.
    localparam logic [LFSR_MAX_W-1:0] DEFAULT_TAPS = 32'h0000_00B8;

    // Fibonacci step. Narrower users zero-extend x and taps, then keep the low bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] x,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {x[LFSR_MAX_W-2:0], ^(x & taps)};
    endfunction

endpackage

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: self-synchronises to the generator stream, then
// flags and counts every sample that departs from the predicted sequence.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
    parameter int               LOCK_COUNT = 4,
    parameter int               LOSS_COUNT = 3,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W   = $clog2(LOSS_COUNT + 1);
    localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [BAD_W-1:0]   LOSS_LAST = BAD_W'(LOSS_COUNT - 1);

    lfsr_state_t        state;
    logic [WIDTH-1:0]   pred;
    logic [MATCH_W-1:0] match_cnt;
    logic [BAD_W-1:0]   bad_run;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        logic [LFSR_MAX_W-1:0] wide;
        wide = lfsr_next(LFSR_MAX_W'(x), LFSR_MAX_W'(TAPS));
        return wide[WIDTH-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            pred      <= '0;
            match_cnt <= '0;
            bad_run   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else if (clear) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (data_valid) begin
                case (state)
                    SEARCH: begin
                        // Zero is the lock-up state and can never seed a valid sequence.
                        if (data_in != '0) begin
                            pred      <= step(data_in);
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (data_in == pred) begin
                            pred      <= step(data_in);
                            match_cnt <= match_cnt + MATCH_W'(1);
                            if (match_cnt == LOCK_LAST) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                // A clear taken mid-lock may have left a partial bad run behind.
                                bad_run <= '0;
                            end
                        end else if (data_in != '0) begin
                            pred      <= step(data_in);
                            match_cnt <= '0;
                        end else begin
                            state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        // Flywheel on the prediction so corrupted samples never disturb it.
                        pred <= step(pred);
                        if (data_in == pred) begin
                            bad_run <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            err_count <= sat_inc(err_count);
                            if (bad_run == LOSS_LAST) begin
                                state   <= SEARCH;
                                locked  <= 1'b0;
                                bad_run <= '0;
                            end else begin
                                bad_run <= bad_run + BAD_W'(1);
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion to the 8-bit LFSR random-number generator. Samples the generator's output stream, self-synchronises to it, then flags every sample that deviates from the predicted LFSR sequence. Used in bring-up and BIST paths downstream of the generator, or after a link that carries its output, to measure error rate.

## Interface
- WIDTH, 8: LFSR / data width.
- TAPS, 8'hB8: Fibonacci feedback mask. Bits 7,5,4,3 give x^8+x^6+x^5+x^4+1, which is maximal length with period 255.
- LOCK_COUNT, 4: consecutive correct predictions required to declare lock (>=1).
- LOSS_COUNT, 3: consecutive mispredictions while locked that drop lock (>=1).
- CNT_W, 16: error counter width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  WIDTH  received sample (the generator's RandNum).
- data_valid  in  1  data_in is a new sample this cycle.
- clear  in  1  synchronous clear of err_count; returns the checker to SEARCH.
- locked  out  1  checker is synchronised.
- err_pulse  out  1  one-cycle strobe per mispredicted sample while locked.
- err_count  out  CNT_W  saturating count of err_pulse events.

## Operation
- Step function: next(x) = {x[WIDTH-2:0], ^(x & TAPS)}.
- States: SEARCH, VERIFY, LOCKED. Internal registers: pred (WIDTH), match_cnt, bad_run.
- With data_valid low, no register changes and err_pulse is 0.
- SEARCH, valid sample:
  - Sample nonzero: pred <= next(data_in), match_cnt <= 0, go to VERIFY.
  - Sample zero: ignored, because zero is the LFSR lock-up state.
- VERIFY, valid sample:
  - data_in == pred: pred <= next(data_in), match_cnt++. When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked <= 1.
  - Mismatch and data_in nonzero: reseed (pred <= next(data_in), match_cnt <= 0), stay in VERIFY.
  - Mismatch and data_in zero: go to SEARCH.
  - No errors are counted in VERIFY.
- LOCKED, valid sample:
  - pred <= next(pred). The checker flywheels on its own prediction, so a corrupted sample never corrupts pred.
  - Match: bad_run <= 0.
  - Mismatch: err_pulse <= 1, err_count saturating-increments (holds at all-ones), bad_run++.
  - When bad_run reaches LOSS_COUNT: go to SEARCH, locked <= 0, bad_run <= 0. The final mismatch is still counted.
- clear:
  - Takes priority over data_valid; the sample in that cycle is dropped.
  - err_count <= 0, state <= SEARCH, locked <= 0, err_pulse <= 0.
- rst: same as clear, and also zeroes pred, match_cnt and bad_run.

## Timing
- Reset values: locked 0, err_pulse 0, err_count 0, state SEARCH.
- All outputs are registered.
  - err_pulse and err_count update in the cycle after the offending valid sample.
  - locked rises in the cycle after the (LOCK_COUNT+1)-th consecutive valid correct sample, counting the seeding sample.
  - locked falls in the cycle after the LOSS_COUNT-th consecutive mismatch.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.
- Gaps in data_valid are transparent: the prediction advances only on valid samples.
- rst or clear asserted mid-lock: locked is 0 on the next cycle and err_count reads 0.

## Structure
- Shared package lfsr_pkg holds:
  - State enum (SEARCH/VERIFY/LOCKED).
  - Default TAPS constant.
  - Function lfsr_next(x, taps), reused by the generator so both ends implement one polynomial.
- No sub-module: a single clocked FSM with the step function inlined from the package.

## Test plan
- Lock-up: reset, then feed seed 8'hD5 with valid each cycle. The expected sequence is D5, AA, 55, AB, 57, ... so locked must rise the cycle after 8'h57 is sampled, with err_count still 0.
- Single error: after lock, replace one expected sample with 8'hFF.
  - Required: exactly one err_pulse, err_count = 1, locked stays 1.
  - The following samples match again without any re-acquisition.
- Loss of lock: after lock, feed 3 consecutive wrong samples. Required: err_count = 3, locked drops after the third, state SEARCH, then re-lock after 5 correct samples.
- Zero / garbage in SEARCH: feed 8'h00 repeatedly → stays in SEARCH. Then feed D5, AA, 12 → reseeds at 12 and does not lock.
- Valid gaps and clear: drive data_valid in an alternating pattern over the generator sequence → locks with no errors. Then assert clear in the same cycle as a wrong sample → err_count 0, locked 0, no err_pulse.
- Saturation: with CNT_W = 4, hold in LOCKED (LOSS_COUNT = 255) and inject 20 isolated errors → err_count stays at 4'hF.
